// File: rtl/ram_image_port_if.sv
// Stream and RAM-bus bundle for the image port.
// master: the port itself; slave: host stream + RAM side.
interface ram_image_port_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] ram_address;
  logic [15:0]       ram_wdata;
  logic              ram_wr_en;
  logic              ram_rd_en;
  logic [15:0]       ram_rdata;

  modport master (
    input  in_data, in_valid, out_ready, ram_rdata,
    output in_ready, out_data, out_valid,
    output ram_address, ram_wdata, ram_wr_en, ram_rd_en
  );

  modport slave (
    output in_data, in_valid, out_ready, ram_rdata,
    input  in_ready, out_data, out_valid,
    input  ram_address, ram_wdata, ram_wr_en, ram_rd_en
  );
endinterface

// File: rtl/ram_image_port.sv
// Host-side RAM image port: packs a byte stream into
// 16-bit RAM words (load) and unpacks them back out (dump).
module ram_image_port #(
  parameter int ADDR_W   = 8,
  parameter bit LO_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  ram_image_port_if.master  bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE,
    LD_B0,
    LD_B1,
    LD_WR,
    DP_RD,
    DP_CAP,
    DP_B0,
    DP_B1,
    FIN
  } state_t;

  localparam logic [ADDR_W:0] MAX_WORDS =
    {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   rem;
  logic [ADDR_W:0]   cnt_clamp;
  logic [15:0]       word;
  logic [7:0]        byte_first;
  logic [7:0]        byte_second;

  // Requested length clamped to the RAM size
  always_comb begin
    cnt_clamp = word_count;
    if (word_count > MAX_WORDS) cnt_clamp = MAX_WORDS;
  end

  // Stream order of the two halves of the held word
  always_comb begin
    byte_first  = LO_FIRST ? word[7:0]  : word[15:8];
    byte_second = LO_FIRST ? word[15:8] : word[7:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and all port outputs
  always_comb begin
    nxt             = state;
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.out_data    = 8'h00;
    bus.ram_address = '0;
    bus.ram_wdata   = 16'h0000;
    bus.ram_wr_en   = 1'b0;
    bus.ram_rd_en   = 1'b0;
    busy            = (state != IDLE);
    done            = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_load) begin
          nxt = (cnt_clamp == '0) ? FIN : LD_B0;
        end else if (start_dump) begin
          nxt = (cnt_clamp == '0) ? FIN : DP_RD;
        end
      end
      LD_B0: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) nxt = LD_B1;
      end
      LD_B1: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) nxt = LD_WR;
      end
      LD_WR: begin
        bus.ram_wr_en   = 1'b1;
        bus.ram_address = addr;
        bus.ram_wdata   = word;
        nxt = (rem == 1) ? FIN : LD_B0;
      end
      DP_RD: begin
        bus.ram_rd_en   = 1'b1;
        bus.ram_address = addr;
        nxt = DP_CAP;
      end
      DP_CAP: begin
        nxt = DP_B0;
      end
      DP_B0: begin
        bus.out_valid = 1'b1;
        bus.out_data  = byte_first;
        if (bus.out_ready) nxt = DP_B1;
      end
      DP_B1: begin
        bus.out_valid = 1'b1;
        bus.out_data  = byte_second;
        if (bus.out_ready) begin
          nxt = (rem == '0) ? FIN : DP_RD;
        end
      end
      FIN: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Address, word counter and packing/capture register
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      rem  <= '0;
      word <= 16'h0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_load || start_dump) begin
            addr <= base_addr;
            rem  <= cnt_clamp;
          end
        end
        LD_B0: begin
          if (bus.in_valid) begin
            if (LO_FIRST) word[7:0]  <= bus.in_data;
            else          word[15:8] <= bus.in_data;
          end
        end
        LD_B1: begin
          if (bus.in_valid) begin
            if (LO_FIRST) word[15:8] <= bus.in_data;
            else          word[7:0]  <= bus.in_data;
          end
        end
        LD_WR: begin
          addr <= addr + 1'b1;
          rem  <= rem - 1'b1;
        end
        DP_CAP: begin
          word <= bus.ram_rdata;
          addr <= addr + 1'b1;
          rem  <= rem - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
